// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared AHB encodings, arbiter state type and burst length lookup
package ahb_arb_pkg;
  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_WRAP4 = 3'd2, HB_INCR4 = 3'd3;
  localparam logic [2:0] HB_WRAP8 = 3'd4, HB_INCR8 = 3'd5, HB_WRAP16 = 3'd6, HB_INCR16 = 3'd7;
  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;
  // Beats in a fixed-length burst; 0 means no hold (SINGLE or undefined-length INCR)
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    return hburst == HB_SINGLE || hburst == HB_INCR ? 5'd0
         : hburst inside {HB_WRAP4, HB_INCR4} ? 5'd4
         : hburst inside {HB_WRAP8, HB_INCR8} ? 5'd8
         : hburst inside {HB_WRAP16, HB_INCR16} ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: rotating-priority encoder, first requester after ptr wins
module ahb_rr_pick (
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic        valid,
  output logic [3:0]  idx
);
  // Scan from farthest to nearest so the closest requester after ptr overwrites the rest
  always_comb begin
    valid = 1'b0;
    idx = 4'd0;
    for (int i = 16; i > 0; i--)
      if (req[ptr + 4'(i)]) begin
        valid = 1'b1;
        idx = ptr + 4'(i);
      end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter holding the bus through fixed bursts and locks
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic [15:0] HBUSREQ_i,
  input  logic [15:0] HLOCK_i,
  input  logic [1:0]  HTRANS_i,
  input  logic [2:0]  HBURST_i,
  input  logic        HREADY_i,
  output logic [15:0] HGRANT_o,
  output logic [3:0]  HMASTER_o,
  output logic        HMASTLOCK_o
);
  localparam logic [15:0] MASK = NUM_MASTERS >= 16 ? 16'hFFFF : 16'((1 << NUM_MASTERS) - 1);
  localparam logic [3:0] DEF = 4'(DEFAULT_MASTER);
  state_t state, state_n;
  logic [15:0] req;
  logic [4:0] blen;
  logic [3:0] beat_cnt, cnt_n, gidx, gidx_n, rr_ptr, pick_idx;
  logic pick_v, lk, in_burst;
  assign req = HBUSREQ_i & MASK;
  assign lk = HLOCK_i[gidx] & req[gidx];
  assign in_burst = state != ARB && beat_cnt != 4'd0;
  assign blen = burst_len(HBURST_i);
  ahb_rr_pick u_pick (.req(req), .ptr(rr_ptr), .valid(pick_v), .idx(pick_idx));
  // State register, frozen while the bus is stalled
  always_ff @(posedge HCLK)
    if (HRST) state <= ARB;
    else if (HREADY_i) state <= state_n;
  // Next state: a held lock outranks a burst, a burst in flight outranks free arbitration
  always_comb state_n = lk ? LOCK : cnt_n != 4'd0 ? BURST : ARB;
  // Beat counter next value and next grant; grant only moves when nothing holds the bus
  always_comb begin
    cnt_n = HTRANS_i == HT_NONSEQ && blen != 5'd0 ? 4'(blen - 5'd1)
          : !in_burst ? beat_cnt
          : HTRANS_i inside {HT_IDLE, HT_NONSEQ} ? 4'd0
          : HTRANS_i == HT_SEQ ? beat_cnt - 4'd1 : beat_cnt;
    gidx_n = state_n != ARB ? gidx : pick_v ? pick_idx : DEF;
  end
  // Counter, pointer and registered bus outputs; HMASTER_o trails the grant by one accepted phase
  always_ff @(posedge HCLK)
    if (HRST) begin
      beat_cnt <= 4'd0;
      rr_ptr <= DEF;
      gidx <= DEF;
      HGRANT_o <= 16'd1 << DEF;
      HMASTER_o <= DEF;
      HMASTLOCK_o <= 1'b0;
    end else if (HREADY_i) begin
      beat_cnt <= cnt_n;
      if (state_n == ARB && pick_v) rr_ptr <= pick_idx;
      gidx <= gidx_n;
      HGRANT_o <= 16'd1 << gidx_n;
      HMASTER_o <= gidx;
      HMASTLOCK_o <= lk;
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed vector table plus a reset-mid-burst sequence
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;
  logic HCLK = 1'b0;
  logic HRST, HREADY_i, HMASTLOCK_o;
  logic [15:0] HBUSREQ_i, HLOCK_i, HGRANT_o;
  logic [1:0] HTRANS_i;
  logic [2:0] HBURST_i;
  logic [3:0] HMASTER_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int rst, req, lck, tr, bu, rdy, gnt, mst, mlk, cnt;
  } vec_t;
  vec_t vq[$];

  always #5 HCLK = ~HCLK;

  ahb_arbiter dut (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ_i(HBUSREQ_i), .HLOCK_i(HLOCK_i),
    .HTRANS_i(HTRANS_i), .HBURST_i(HBURST_i), .HREADY_i(HREADY_i),
    .HGRANT_o(HGRANT_o), .HMASTER_o(HMASTER_o), .HMASTLOCK_o(HMASTLOCK_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, req, lck, tr, bu, rdy, gnt, mst, mlk, cnt);
    vq.push_back('{rst, req, lck, tr, bu, rdy, gnt, mst, mlk, cnt});
  endtask

  task automatic drive(input int rst, req, lck, tr, bu, rdy);
    HRST = rst[0];
    HBUSREQ_i = 16'(req);
    HLOCK_i = 16'(lck);
    HTRANS_i = 2'(tr);
    HBURST_i = 3'(bu);
    HREADY_i = rdy[0];
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input int gnt, mst, mlk, cnt);
    chk({tag, " gnt"}, int'(HGRANT_o), gnt);
    chk({tag, " mst"}, int'(HMASTER_o), mst);
    chk({tag, " mlk"}, int'(HMASTLOCK_o), mlk);
    chk({tag, " cnt"}, int'(dut.beat_cnt), cnt);
  endtask

  initial begin
    //  rst req      lock     htrans     hburst     rdy gnt      mst mlk cnt
    add(1, 'h0000, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0001, 0, 0, 0);
    add(0, 'h0000, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0001, 0, 0, 0);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_SINGLE, 1, 'h0002, 0, 0, 0);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_SINGLE, 1, 'h0004, 1, 0, 0);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_SINGLE, 1, 'h0002, 2, 0, 0);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_SINGLE, 1, 'h0004, 1, 0, 0);
    add(0, 'h0002, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0002, 2, 0, 0);
    add(0, 'h0002, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0002, 1, 0, 0);
    add(0, 'h000A, 'h0000, HT_NONSEQ, HB_INCR4,  1, 'h0002, 1, 0, 3);
    add(0, 'h000A, 'h0000, HT_SEQ,    HB_INCR4,  1, 'h0002, 1, 0, 2);
    add(0, 'h000A, 'h0000, HT_BUSY,   HB_INCR4,  1, 'h0002, 1, 0, 2);
    add(0, 'h000A, 'h0000, HT_SEQ,    HB_INCR4,  1, 'h0002, 1, 0, 1);
    add(0, 'h000A, 'h0000, HT_SEQ,    HB_INCR4,  1, 'h0008, 1, 0, 0);
    add(0, 'h0008, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0008, 3, 0, 0);
    add(0, 'h000A, 'h0000, HT_NONSEQ, HB_INCR8,  1, 'h0008, 3, 0, 7);
    add(0, 'h000A, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0008, 3, 0, 6);
    add(0, 'h000A, 'h0000, HT_IDLE,   HB_INCR8,  1, 'h0002, 3, 0, 0);
    add(0, 'h0002, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0002, 1, 0, 0);
    add(0, 'h0002, 'h0000, HT_NONSEQ, HB_WRAP4,  1, 'h0002, 1, 0, 3);
    add(0, 'h0002, 'h0000, HT_SEQ,    HB_WRAP4,  1, 'h0002, 1, 0, 2);
    add(0, 'h0002, 'h0000, HT_NONSEQ, HB_INCR16, 1, 'h0002, 1, 0, 15);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_SINGLE, 1, 'h0004, 1, 0, 0);
    add(0, 'h0004, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0004, 2, 0, 0);
    add(0, 'h0006, 'h0000, HT_NONSEQ, HB_INCR8,  1, 'h0004, 2, 0, 7);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 6);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 5);
    for (int i = 0; i < 5; i++)
      add(0, 'h0006, 'h0000, HT_SEQ,  HB_INCR8,  0, 'h0004, 2, 0, 5);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 4);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 3);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 2);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0004, 2, 0, 1);
    add(0, 'h0006, 'h0000, HT_SEQ,    HB_INCR8,  1, 'h0002, 2, 0, 0);
    add(0, 'h0002, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0002, 1, 0, 0);
    add(0, 'h003F, 'h0004, HT_IDLE,   HB_SINGLE, 1, 'h0004, 1, 0, 0);
    add(0, 'h003F, 'h0004, HT_IDLE,   HB_SINGLE, 1, 'h0004, 2, 1, 0);
    add(0, 'h003F, 'h0004, HT_IDLE,   HB_SINGLE, 1, 'h0004, 2, 1, 0);
    add(0, 'h003F, 'h0004, HT_NONSEQ, HB_INCR4,  1, 'h0004, 2, 1, 3);
    add(0, 'h003F, 'h0004, HT_SEQ,    HB_INCR4,  1, 'h0004, 2, 1, 2);
    add(0, 'h003F, 'h0004, HT_SEQ,    HB_INCR4,  1, 'h0004, 2, 1, 1);
    add(0, 'h003F, 'h0004, HT_SEQ,    HB_INCR4,  1, 'h0004, 2, 1, 0);
    add(0, 'h003F, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0008, 2, 0, 0);
    add(0, 'h0000, 'h0000, HT_IDLE,   HB_SINGLE, 1, 'h0001, 3, 0, 0);

    HRST = 1'b1;
    HBUSREQ_i = '0;
    HLOCK_i = '0;
    HTRANS_i = HT_IDLE;
    HBURST_i = HB_SINGLE;
    HREADY_i = 1'b1;
    #2;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].req, vq[i].lck, vq[i].tr, vq[i].bu, vq[i].rdy);
      chk_out($sformatf("v%0d", i), vq[i].gnt, vq[i].mst, vq[i].mlk, vq[i].cnt);
    end

    // Reset landing on the second beat of a WRAP16
    drive(0, 'h0002, 'h0000, HT_IDLE, HB_SINGLE, 1);
    chk_out("w1", 'h0002, 0, 0, 0);
    drive(0, 'h0002, 'h0000, HT_IDLE, HB_SINGLE, 1);
    chk_out("w2", 'h0002, 1, 0, 0);
    drive(0, 'h0002, 'h0000, HT_NONSEQ, HB_WRAP16, 1);
    chk_out("w3", 'h0002, 1, 0, 15);
    chk("w3 state", int'(dut.state), int'(BURST));
    drive(1, 'h0002, 'h0000, HT_SEQ, HB_WRAP16, 1);
    chk_out("rst", 'h0001, 0, 0, 0);
    chk("rst state", int'(dut.state), int'(ARB));
    chk("rst ptr", int'(dut.rr_ptr), 0);
    drive(0, 'h0002, 'h0000, HT_NONSEQ, HB_SINGLE, 1);
    chk_out("post", 'h0002, 0, 0, 0);
    chk("post state", int'(dut.state), int'(ARB));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
